// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the single register-file write port between the execute unit (ex)
//   and the load unit (ld). Keeps a pending-load scoreboard so that decode can
//   stall on read-after-load hazards.
//
//   Arbitration is combinational. A one-bit priority pointer changes only on
//   contention cycles, and it moves to favour the loser. The granted write is
//   registered once before it reaches the write port. Address 0 on the write
//   port means "no write".
//
// Ports
//   clock, reset            rising-edge clock; asynchronous active-high reset
//   ex_valid/rd/data/ready  execute write-back request and its grant
//   ld_valid/rd/data/ready  load write-back request and its grant
//   iss_valid, iss_rd       load issue; marks iss_rd as pending
//   rs1_addr, rs2_addr      decode source registers
//   rs1_busy, rs2_busy      source register has a load write outstanding
//   rd_addr, w_val          registered regfile write port
//   pend_mask               scoreboard bits for debug (bit 0 is always 0)
//   waw_err                 sticky flag for an ex write to a pending register;
//                           present only when REGFILE_WB_ARBITER_WAW_CHECK_EN
//                           is defined
module regfile_wb_arbiter #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic [AW-1:0]     ex_rd,
    input  logic [XLEN-1:0]   ex_data,
    output logic              ex_ready,
    input  logic              ld_valid,
    input  logic [AW-1:0]     ld_rd,
    input  logic [XLEN-1:0]   ld_data,
    output logic              ld_ready,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_rd,
    input  logic [AW-1:0]     rs1_addr,
    input  logic [AW-1:0]     rs2_addr,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic [AW-1:0]     rd_addr,
    output logic [XLEN-1:0]   w_val,
    output logic [2**AW-1:0]  pend_mask
`ifdef REGFILE_WB_ARBITER_WAW_CHECK_EN
    ,
    output logic              waw_err
`endif
);

    localparam int NREG = 2**AW;

    logic            prio;      // 0: ex wins a contention, 1: ld wins
    logic            ex_acc;
    logic            ld_acc;
    logic [NREG-1:0] pend;

    // Grant logic. At most one ready can be high in a cycle.
    assign ex_ready = ex_valid & (~ld_valid | ~prio);
    assign ld_ready = ld_valid & (~ex_valid |  prio);
    assign ex_acc   = ex_ready;   // ready already implies valid
    assign ld_acc   = ld_ready;

    // The pointer moves only on contention. It then favours the requester
    // that lost, so a requester held valid is granted within two cycles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            prio <= 1'b0;
        else if (ex_valid && ld_valid)
            prio <= ex_acc;
    end

    // Output stage. An accepted rd = 0 still uses the slot, but the write it
    // produces is a no-op on the port.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_addr <= '0;
            w_val   <= '0;
        end else if (ex_acc) begin
            rd_addr <= ex_rd;
            w_val   <= ex_data;
        end else if (ld_acc) begin
            rd_addr <= ld_rd;
            w_val   <= ld_data;
        end else begin
            rd_addr <= '0;
            w_val   <= '0;
        end
    end

    // Scoreboard. Each bit is a set/clear flop. When set and clear hit the
    // same register in one cycle, set wins: a new load to that rd was issued.
    // The clear happens on the edge that loads the output stage. The regfile
    // forwards w_val in the next cycle, so a dependent read is safe then.
    assign pend[0] = 1'b0;
    for (genvar i = 1; i < NREG; i++) begin : g_pend
        always_ff @(posedge clock or posedge reset) begin
            if (reset)
                pend[i] <= 1'b0;
            else if (iss_valid && iss_rd == AW'(i))
                pend[i] <= 1'b1;
            else if (ld_acc && ld_rd == AW'(i))
                pend[i] <= 1'b0;
        end
    end

    assign pend_mask = pend;
    // pend[0] is constant 0, so register 0 can never show as busy.
    assign rs1_busy  = pend[rs1_addr];
    assign rs2_busy  = pend[rs2_addr];

`ifdef REGFILE_WB_ARBITER_WAW_CHECK_EN
    // Sticky flag: an ex write reached a register that still has a load
    // outstanding. Only reset clears it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            waw_err <= 1'b0;
        else if (ex_acc && pend[ex_rd])
            waw_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NREG = 32;

    logic            clock = 1'b0;
    logic            reset;
    logic            ex_valid, ld_valid, iss_valid;
    logic [AW-1:0]   ex_rd, ld_rd, iss_rd, rs1_addr, rs2_addr;
    logic [XLEN-1:0] ex_data, ld_data;
    logic            ex_ready, ld_ready, rs1_busy, rs2_busy;
    logic [AW-1:0]   rd_addr;
    logic [XLEN-1:0] w_val;
    logic [NREG-1:0] pend_mask;
`ifdef REGFILE_WB_ARBITER_WAW_CHECK_EN
    logic            waw_err;
`endif

    regfile_wb_arbiter #(.XLEN(XLEN), .AW(AW)) dut (
        .clock(clock), .reset(reset),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_data(ex_data), .ex_ready(ex_ready),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rd_addr(rd_addr), .w_val(w_val), .pend_mask(pend_mask)
`ifdef REGFILE_WB_ARBITER_WAW_CHECK_EN
        , .waw_err(waw_err)
`endif
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Reference model: the set of pending registers, plus which requester
    // won the last contention (the other one wins the next contention).
    bit              m_pend[NREG];
    bit              m_ex_won_last;
    bit              m_waw;
    logic [AW-1:0]   m_rd;
    logic [XLEN-1:0] m_val;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NREG-1:0] m_mask();
        logic [NREG-1:0] m;
        for (int i = 0; i < NREG; i++) m[i] = m_pend[i];
        return m;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NREG; i++) m_pend[i] = 1'b0;
        m_ex_won_last = 1'b0;
        m_waw = 1'b0;
        m_rd  = '0;
        m_val = '0;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".rd_addr"}, 64'(rd_addr), 64'(m_rd));
        chk({tag, ".w_val"}, 64'(w_val), 64'(m_val));
        chk({tag, ".pend_mask"}, 64'(pend_mask), 64'(m_mask()));
`ifdef REGFILE_WB_ARBITER_WAW_CHECK_EN
        chk({tag, ".waw_err"}, 64'(waw_err), 64'(m_waw));
`endif
    endtask

    // One clock cycle. Inputs are driven at the falling edge. Combinational
    // outputs are checked before the rising edge, registered outputs after it.
    task automatic cycle(input string tag,
                         input bit ev, input logic [AW-1:0] erd, input logic [XLEN-1:0] edat,
                         input bit lv, input logic [AW-1:0] lrd, input logic [XLEN-1:0] ldat,
                         input bit iv, input logic [AW-1:0] ird,
                         input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        bit eg, lg;
        @(negedge clock);
        ex_valid = ev;  ex_rd = erd;  ex_data = edat;
        ld_valid = lv;  ld_rd = lrd;  ld_data = ldat;
        iss_valid = iv; iss_rd = ird;
        rs1_addr = r1;  rs2_addr = r2;
        #1;
        if (ev && lv) begin
            eg = !m_ex_won_last;
            lg = m_ex_won_last;
        end else begin
            eg = ev;
            lg = lv;
        end
        chk({tag, ".ex_ready"}, 64'(ex_ready), 64'(eg));
        chk({tag, ".ld_ready"}, 64'(ld_ready), 64'(lg));
        chk({tag, ".rs1_busy"}, 64'(rs1_busy), 64'(r1 != 0 && m_pend[r1]));
        chk({tag, ".rs2_busy"}, 64'(rs2_busy), 64'(r2 != 0 && m_pend[r2]));
        @(posedge clock);
        if (eg && erd != 0 && m_pend[erd]) m_waw = 1'b1;
        if (ev && lv) m_ex_won_last = eg;
        m_rd  = eg ? erd  : lg ? lrd  : '0;
        m_val = eg ? edat : lg ? ldat : '0;
        if (lg) m_pend[lrd] = 1'b0;
        if (iv && ird != 0) m_pend[ird] = 1'b1;
        m_pend[0] = 1'b0;
        #1;
        check_regs(tag);
    endtask

    task automatic idle(input string tag);
        cycle(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        ex_valid = 0; ld_valid = 0; iss_valid = 0;
        ex_rd = 0; ld_rd = 0; iss_rd = 0; rs1_addr = 0; rs2_addr = 0;
        ex_data = 0; ld_data = 0;
        reset = 1'b1;
        m_reset();
        #12;
        check_regs("reset");
        chk("reset.ex_ready", 64'(ex_ready), 64'(0));
        @(negedge clock);
        reset = 1'b0;

        // A single ex write reaches the port one cycle later, then the port idles.
        cycle("ex1", 1, 5, 32'h11, 0, 0, 0, 0, 0, 0, 0);
        chk("ex1.rd5", 64'(rd_addr), 64'(5));
        idle("ex1_after");
        chk("ex1.rd0", 64'(rd_addr), 64'(0));

        // Sustained contention: grants alternate ex, ld, ex, ld.
        cycle("cont0", 1, 1, 32'hA, 1, 2, 32'hB, 0, 0, 0, 0);
        chk("cont0.rd", 64'(rd_addr), 64'(1));
        cycle("cont1", 1, 1, 32'hA, 1, 2, 32'hB, 0, 0, 0, 0);
        chk("cont1.rd", 64'(rd_addr), 64'(2));
        cycle("cont2", 1, 1, 32'hA, 1, 2, 32'hB, 0, 0, 0, 0);
        chk("cont2.rd", 64'(rd_addr), 64'(1));
        cycle("cont3", 1, 1, 32'hA, 1, 2, 32'hB, 0, 0, 0, 0);
        chk("cont3.rd", 64'(rd_addr), 64'(2));

        // Issue a load to r7. r7 reads busy until the ld write lands.
        cycle("iss7", 0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
        chk("iss7.bit7", 64'(pend_mask[7]), 64'(1));
        cycle("ld7", 0, 0, 0, 1, 7, 32'h77, 0, 0, 7, 0);
        chk("ld7.busy_pre", 64'(rs1_busy), 64'(0));
        chk("ld7.rd", 64'(rd_addr), 64'(7));
        idle("ld7_after");

        // Issue and clear of r9 in the same cycle: the set wins.
        cycle("iss9", 0, 0, 0, 0, 0, 0, 1, 9, 0, 9);
        cycle("iss9_ld9", 0, 0, 0, 1, 9, 32'h99, 1, 9, 0, 9);
        cycle("busy9", 0, 0, 0, 0, 0, 0, 0, 0, 0, 9);
        chk("busy9.rs2", 64'(rs2_busy), 64'(1));

        // Asynchronous reset in the middle of a cycle, with a write latched in
        // the output stage.
        cycle("ld3", 0, 0, 0, 1, 3, 32'h33, 0, 0, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        m_reset();
        chk("async.rd_addr", 64'(rd_addr), 64'(0));
        chk("async.w_val", 64'(w_val), 64'(0));
        chk("async.pend_mask", 64'(pend_mask), 64'(0));
        @(negedge clock);
        reset = 1'b0;
        // Reset returns the pointer to favour ex.
        cycle("post_rst", 1, 1, 32'hA, 1, 2, 32'hB, 0, 0, 0, 0);
        chk("post_rst.rd", 64'(rd_addr), 64'(1));

`ifdef REGFILE_WB_ARBITER_WAW_CHECK_EN
        cycle("waw_iss", 0, 0, 0, 0, 0, 0, 1, 4, 0, 0);
        cycle("waw_ex", 1, 4, 32'h44, 0, 0, 0, 0, 0, 0, 0);
        chk("waw.set", 64'(waw_err), 64'(1));
        idle("waw_hold");
        chk("waw.sticky", 64'(waw_err), 64'(1));
`endif

        // Random traffic. A narrow register range makes hazards frequent.
        for (int n = 0; n < 400; n++) begin
            cycle("rand",
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom(),
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom(),
                  1'($urandom_range(0, 2) == 0), AW'($urandom_range(0, 7)),
                  AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (rd_addr/w_val) between two write-back requesters: the execute unit (ex) and the load unit (ld).
- Drives the write port from a registered stage, one write per cycle. rd_addr = 0 means "no write", per the regfile contract.
- Keeps a pending-write scoreboard for in-flight loads and flags read hazards on the decode source registers.
- Sits between the ex/ld write-back outputs and the regfile write port; the busy flags feed the decode stall logic.

Parameters:
XLEN, 32, data width of w_val and the requester data.
AW, 5, register address width; the register count is 2**AW.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
ex_valid  in  1  execute write-back request.
ex_rd  in  AW  execute destination register.
ex_data  in  XLEN  execute result.
ex_ready  out  1  execute request accepted this cycle (combinational).
ld_valid  in  1  load write-back request.
ld_rd  in  AW  load destination register.
ld_data  in  XLEN  load result.
ld_ready  out  1  load request accepted this cycle (combinational).
iss_valid  in  1  a load is issued this cycle.
iss_rd  in  AW  destination register of the issued load.
rs1_addr  in  AW  decode source register 1.
rs2_addr  in  AW  decode source register 2.
rs1_busy  out  1  rs1 has a load write outstanding.
rs2_busy  out  1  rs2 has a load write outstanding.
rd_addr  out  AW  regfile write address (registered).
w_val  out  XLEN  regfile write data (registered).
pend_mask  out  2**AW  scoreboard bits, for debug; bit 0 is always 0.

Behaviour:
- Reset (asynchronous, active-high), applies at any time including mid-transfer:
  - rd_addr = 0, w_val = 0, prio = 0, pend_mask = 0.
  - A write latched in the output stage is dropped.
  - ex_ready and ld_ready follow the combinational rules below, with prio = 0.
- Arbitration, combinational:
  - Only one valid: that requester gets ready = 1.
  - Both valid: prio = 0 grants ex, prio = 1 grants ld.
  - Neither valid: both ready = 0.
  - At most one ready is high per cycle.
  - accept = valid & ready.
- Priority pointer:
  - Updated only on a contention cycle (both valid). It flips to favour the loser: ex wins -> prio = 1, ld wins -> prio = 0.
  - Unchanged on cycles without contention.
  - Result: a requester held valid is accepted within 2 cycles.
- Output stage, latency 1:
  - On the edge after an accept: rd_addr <= granted rd, w_val <= granted data.
  - With no accept: rd_addr <= 0, w_val <= 0.
  - A request with rd = 0 is accepted and consumes the slot; the resulting port write is a no-op.
  - Back-to-back accepts produce back-to-back writes with no bubble.
- Scoreboard, pend[2**AW-1:1]:
  - Set: iss_valid & iss_rd != 0 sets pend[iss_rd] at the clock edge.
  - Clear: an ld accept clears pend[ld_rd] at the same edge that loads the output stage. The regfile forwards w_val on the following cycle, so a dependent read is safe in that cycle.
  - Set and clear of the same register in one cycle: set wins (a new load to the same rd).
  - Issuing a register that is already pending leaves the bit set. No counting; at most one outstanding load per rd.
  - ex writes never touch pend.
  - pend[0] is always 0.
- Busy flags:
  - rsN_busy = (rsN_addr != 0) & pend[rsN_addr], evaluated combinationally on the current pend.
  - Same-cycle iss_valid to that register is not visible until the next cycle.

Optional Feature:
- Macro: REGFILE_WB_ARBITER_WAW_CHECK_EN.
- Defined:
  - Adds output port waw_err (1 bit, sticky).
  - waw_err is set on the edge where an ex accept has ex_rd != 0 and pend[ex_rd] = 1.
  - waw_err is cleared only by reset; its reset value is 0.
- Undefined:
  - The port and its logic are absent.
  - Such ex writes are accepted silently, with identical arbitration and write-port behaviour.

Test Plan:
- After reset, ex_valid=1, ex_rd=5, ex_data=0x11 for one cycle -> ex_ready=1 that cycle; next cycle rd_addr=5, w_val=0x11; the cycle after, rd_addr=0.
- ex and ld both valid for 4 cycles (ex_rd=1/0xA, ld_rd=2/0xB) -> grants ex, ld, ex, ld; rd_addr sequence 1, 2, 1, 2, one cycle delayed.
- iss_valid, iss_rd=7 -> next cycle with rs1_addr=7: rs1_busy=1, pend_mask bit 7 = 1. Then ld accept, ld_rd=7 -> busy drops the next cycle while rd_addr=7.
- Same cycle iss_rd=9 and ld accept with ld_rd=9 (pend[9] already set) -> pend[9] stays 1; rs2_addr=9 gives rs2_busy=1.
- ld_valid, ld_rd=3 accepted, then reset asserted asynchronously mid-cycle -> rd_addr, w_val, pend_mask go to 0 immediately, without waiting for a clock edge; prio=0.
- With REGFILE_WB_ARBITER_WAW_CHECK_EN: issue rd=4, then ex accept with ex_rd=4 -> waw_err=1 and stays 1 until reset.
